// File: rtl/i2c_write_master.sv
// i2c_write_master: I2C write-only master that sends START, address+W, 0..MAX_BYTES data bytes with per-byte ACK check, then STOP
// Ports: clock_25/reset (sync, active-high); start/slave_address/register_data/byte_count request a write;
// i2c_serial_data_input samples the slave ACK; i2c_serial_data_output/_oe drive open-drain SDA;
// i2c_serial_clock is SCL; busy/done/ack_error report transaction status.
module i2c_write_master #(
  parameter int CLK_DIV   = 63,
  parameter int MAX_BYTES = 4,
  parameter int CNT_W     = 3
) (
  input  logic                   clock_25,
  input  logic                   reset,
  input  logic                   start,
  input  logic [6:0]             slave_address,
  input  logic [8*MAX_BYTES-1:0] register_data,
  input  logic [CNT_W-1:0]       byte_count,
  input  logic                   i2c_serial_data_input,
  output logic                   i2c_serial_data_output,
  output logic                   i2c_serial_data_oe,
  output logic                   i2c_serial_clock,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_error
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = 8*MAX_BYTES;
  localparam logic [CNT_W-1:0] MAXB = CNT_W'(MAX_BYTES);
  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [CNT_W-1:0] byte_q, byte_d, cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [PW-1:0] data_q, data_d;
  logic done_q, done_d, err_q, err_d, tick;
  always_ff @(posedge clock_25)
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  always_comb begin
    tick    = state_q != IDLE && div_q == DW'(CLK_DIV-1);
    state_d = state_q;
    div_d   = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = START;
        qtr_d   = '0;
        bit_d   = '0;
        byte_d  = '0;
        err_d   = 1'b0;
        cnt_d   = byte_count > MAXB ? MAXB : byte_count;
        sh_d    = {slave_address, 1'b0};
        data_d  = register_data;
      end
      START: if (tick) begin
        state_d = qtr_q == 2'd2 ? BIT : START;
        qtr_d   = qtr_q == 2'd2 ? 2'd0 : qtr_q + 2'd1;
      end
      BIT: if (tick) begin
        qtr_d = qtr_q + 2'd1;
        // bit counter wraps 7->0 on the way into the ACK slot
        if (qtr_q == 2'd3) begin
          state_d = bit_q == 3'd7 ? ACK : BIT;
          bit_d   = bit_q + 3'd1;
          sh_d    = sh_q << 1;
        end
      end
      ACK: if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd1 && i2c_serial_data_input) err_d = 1'b1;
        // err_q already holds this slot's sample by Q3; a NACK skips the remaining bytes
        if (qtr_q == 2'd3) begin
          state_d = (err_q || byte_q == cnt_q) ? STOP : BIT;
          sh_d    = data_q[PW-1 -: 8];
          data_d  = data_q << 8;
          byte_d  = byte_q + CNT_W'(1);
        end
      end
      STOP: if (tick) begin
        state_d = qtr_q == 2'd2 ? IDLE : STOP;
        qtr_d   = qtr_q == 2'd2 ? 2'd0 : qtr_q + 2'd1;
        done_d  = qtr_q == 2'd2;
      end
      default: state_d = IDLE;
    endcase
  end
  assign i2c_serial_clock = state_q == START ? qtr_q != 2'd2 :
                            state_q == STOP  ? qtr_q != 2'd0 :
                            state_q == IDLE  ? 1'b1 : ^qtr_q;
  assign i2c_serial_data_output = state_q == START ? qtr_q == 2'd0 :
                                  state_q == STOP  ? qtr_q == 2'd2 :
                                  state_q == BIT   ? sh_q[7] : 1'b1;
  assign i2c_serial_data_oe = state_q != ACK && !i2c_serial_data_output;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign ack_error = err_q;
endmodule

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master: waveform-level reference model and protocol monitor for i2c_write_master
module tb_i2c_write_master;
  localparam int CLK_DIV = 4;
  localparam int MAX_BYTES = 4;
  localparam int CNT_W = 3;
  localparam int PW = 8*MAX_BYTES;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sda_in = 1'b0;
  logic [6:0] addr = '0;
  logic [PW-1:0] data = '0;
  logic [CNT_W-1:0] cnt = '0;
  logic sda_out, sda_oe, scl, busy, done, aerr;
  int asserts = 0, fails = 0, nack_idx = -1;
  logic [5:0] exp_q[$];
  logic idle_err = 1'b0;
  logic pscl = 1'b1, psda = 1'b1, pbusy = 1'b0, hi_valid = 1'b0, err_at_start = 1'b0;
  int bc = 0, stop_at = -1, nrise = 0, hi_start = 0, last_len = 0, rises = 0, ndone = 0;
  int cyc = 0, t_done = -1, t_busy = -1;
  logic [7:0] cur = '0;
  logic [7:0] got[$];
  always #5 clk = ~clk;
  i2c_write_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
    .clock_25(clk), .reset(rst), .start(start), .slave_address(addr),
    .register_data(data), .byte_count(cnt), .i2c_serial_data_input(sda_in),
    .i2c_serial_data_output(sda_out), .i2c_serial_data_oe(sda_oe),
    .i2c_serial_clock(scl), .busy(busy), .done(done), .ack_error(aerr)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    asserts++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at %0t: actual %0h required %0h", nm, $time, act, expv);
    end
  endtask
  function automatic int exp_sent(input int c, input int nk);
    int n = c > MAX_BYTES ? MAX_BYTES : c;
    return (nk >= 0 && nk <= n) ? nk + 1 : n + 1;
  endfunction
  task automatic qp(input logic s, input logic o, input logic e, input logic er);
    repeat (CLK_DIV) exp_q.push_back({s, o, e, H, L, er});
  endtask
  // Expected {scl,sda,oe,busy,done,ack_error} per cycle for one whole transaction
  task automatic build();
    logic [7:0] fr[$];
    int n, sent;
    logic er, v;
    n = int'(cnt) > MAX_BYTES ? MAX_BYTES : int'(cnt);
    fr.push_back({addr, 1'b0});
    for (int k = 0; k < n; k++) fr.push_back(data[PW-1-8*k -: 8]);
    sent = exp_sent(int'(cnt), nack_idx);
    er = L;
    qp(H, H, L, L); qp(H, L, H, L); qp(L, L, H, L);
    for (int b = 0; b < sent; b++) begin
      for (int i = 7; i >= 0; i--) begin
        v = fr[b][i];
        qp(L, v, !v, L); qp(H, v, !v, L); qp(H, v, !v, L); qp(L, v, !v, L);
      end
      qp(L, H, L, L); qp(H, H, L, L);
      er = (b == nack_idx);
      qp(H, H, L, er); qp(L, H, L, er);
    end
    qp(L, L, H, er); qp(H, L, H, er); qp(H, H, L, er);
    exp_q.push_back({H, H, L, L, H, er});
  endtask
  task automatic eval();
    logic [5:0] act, e;
    act = {scl, sda_out, sda_oe, busy, done, aerr};
    e = exp_q.size() > 0 ? exp_q.pop_front() : {H, H, L, L, L, idle_err};
    idle_err = e[0];
    chk("cycle {scl,sda,oe,busy,done,ack_error}", 32'(act), 32'(e));
    cyc++;
    if (done) begin ndone++; t_done = cyc; end
    if (busy) begin
      if (!pbusy) begin
        bc = 0; stop_at = -1; nrise = 0; hi_valid = L; rises = 0; t_busy = cyc; err_at_start = aerr;
      end else bc++;
      if (scl && pscl && sda_out != psda) begin
        if (sda_out) begin nrise++; stop_at = bc; end
        else chk("sda falls under scl high only at START", bc, CLK_DIV);
      end
      if (scl && !pscl) begin
        rises++; hi_valid = H; hi_start = bc;
        if ((rises-1) % 9 == 0) cur = '0;
        if ((rises-1) % 9 < 8) cur = {cur[6:0], sda_out};
        if ((rises-1) % 9 == 7) got.push_back(cur);
      end
      if (!scl && pscl && hi_valid) chk("scl high width", bc - hi_start, 2*CLK_DIV);
    end else begin
      if (pbusy && done) begin
        last_len = bc + 1;
        chk("sda rises under scl high once (STOP)", nrise, 1);
        chk("STOP edge position", stop_at, last_len - CLK_DIV);
      end
      hi_valid = L; rises = 0;
    end
    pscl = scl; psda = sda_out; pbusy = busy;
    sda_in = busy && nack_idx >= 0 && rises == 9*(nack_idx+1);
    if (rst) begin exp_q.delete(); idle_err = L; end
    else if (exp_q.size() == 0 && start) build();
  endtask
  task automatic tick();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(input int n0);
    int k = 0;
    while (ndone == n0 && k < 5000) begin tick(); k++; end
    chk("done within cycle budget", ndone, n0 + 1);
  endtask
  task automatic run(input logic [6:0] a, input int c, input logic [PW-1:0] d, input int nk);
    int n0;
    got.delete(); addr = a; cnt = CNT_W'(c); data = d; nack_idx = nk; n0 = ndone;
    start = H; tick(); start = L;
    wait_done(n0);
    tick(); tick();
  endtask
  initial begin
    int n0, k, c, nk;
    repeat (3) tick();
    chk("reset scl", scl, 1); chk("reset oe", sda_oe, 0); chk("reset busy", busy, 0);
    rst = L; tick();
    run(7'h39, 2, {8'h41, 8'h10, 16'hBEEF}, -1);
    chk("A busy cycles", last_len, 456); chk("A byte count", got.size(), 3);
    chk("A byte0", got[0], 8'h72); chk("A byte1", got[1], 8'h41); chk("A byte2", got[2], 8'h10);
    chk("A ack_error", aerr, 0);
    run(7'h39, 2, {8'h41, 8'h10, 16'hBEEF}, 1);
    chk("B busy cycles", last_len, 312); chk("B byte count", got.size(), 2); chk("B ack_error", aerr, 1);
    run(7'h39, 0, 32'h12345678, -1);
    chk("C busy cycles", last_len, 168); chk("C byte count", got.size(), 1); chk("C byte0", got[0], 8'h72);
    chk("C ack_error cleared", aerr, 0);
    run(7'h2A, 7, 32'hA5C3_0FF0, -1);
    chk("D busy cycles", last_len, 744); chk("D byte count", got.size(), 5); chk("D byte4", got[4], 8'hF0);
    addr = 7'h39; cnt = 3'd1; data = 32'h5500_0000; nack_idx = 0; n0 = ndone;
    start = H; tick(); start = L;
    repeat (40) tick();
    start = H; tick(); start = L;
    repeat (20) tick();
    start = H;
    wait_done(n0);
    start = L;
    chk("E first length ignores mid pulse", last_len, 168);
    tick();
    chk("E restart on first idle cycle", t_busy - t_done, 1);
    chk("E ack_error cleared at accept", err_at_start, 0);
    wait_done(n0 + 1);
    tick(); tick();
    chk("E second ack_error", aerr, 1); chk("E back to idle", busy, 0);
    addr = 7'h39; cnt = 3'd2; data = 32'h4110_0000; nack_idx = -1;
    start = H; tick(); start = L;
    k = 0;
    while (rises < 13 && k < 2000) begin tick(); k++; end
    chk("F reached data byte 1", int'(rises >= 13), 1);
    rst = H; tick();
    chk("F reset scl", scl, 1); chk("F reset oe", sda_oe, 0);
    chk("F reset busy", busy, 0); chk("F reset done", done, 0);
    rst = L; tick();
    run(7'h39, 2, {8'h41, 8'h10, 16'h0}, -1);
    chk("F clean rerun busy cycles", last_len, 456); chk("F clean rerun bytes", got.size(), 3);
    repeat (25) begin
      c = int'($urandom_range(0, 7));
      nk = int'($urandom_range(0, 6)) - 1;
      run(7'($urandom), c, $urandom, nk);
      chk("R busy cycles", last_len, CLK_DIV*(6 + 36*exp_sent(c, nk)));
      chk("R byte count", got.size(), exp_sent(c, nk));
      chk("R ack_error", aerr, int'(exp_sent(c, nk) == nk + 1));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
Parametrised I2C master write engine for HDMI transmitter configuration. It sends START, a 7-bit slave address with a write bit, then 0..MAX_BYTES data bytes (register address followed by values), checking ACK after every byte, then STOP. It adds a programmable SCL divider, a variable byte count, open-drain SDA enable, per-byte NACK abort and a busy/done handshake. It sits between the configuration sequencer (ROM walker) and the SCL/SDA pads.

Parameters:
CLK_DIV, 63, clock_25 cycles per SCL quarter-period (≥2); 63 gives ~99 kHz SCL.
MAX_BYTES, 4, maximum data bytes after the address byte (≥1).
CNT_W, 3, width of byte_count (holds 0..MAX_BYTES).

Ports:
clock_25  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  transaction request; sampled only in IDLE.
slave_address  in  7  7-bit I2C address; R/W bit is always 0 (write).
register_data  in  8*MAX_BYTES  payload; byte 0 = bits [8*MAX_BYTES-1 -: 8], sent first.
byte_count  in  CNT_W  data bytes to send; 0 = address-only probe.
i2c_serial_data_input  in  1  SDA pad input.
i2c_serial_data_output  out  1  intended SDA level.
i2c_serial_data_oe  out  1  1 = pull SDA low (open-drain enable).
i2c_serial_clock  out  1  SCL.
busy  out  1  transaction in progress.
done  out  1  one-cycle pulse at transaction end.
ack_error  out  1  sticky; slave NACKed the last transaction.

Behaviour:
- Reset values: SCL=1, SDA out=1, oe=0, busy=0, done=0, ack_error=0, state IDLE, divider=0. Reset mid-transaction aborts immediately to these values; the bus is released and no STOP is generated.
- Quarter tick: divider counts 0..CLK_DIV-1 while busy. The tick fires at CLK_DIV-1 and advances the phase. The divider is held at 0 in IDLE.
- oe = ~out, except in ACK slots, where oe=0 and out=1.
- IDLE: if start=1, latch address, register_data and byte_count into internal registers. byte_count > MAX_BYTES clamps to MAX_BYTES. Clear ack_error, set busy=1 on the next cycle, go to START.
- start while busy is ignored. start held high through done begins a new transaction on the first IDLE cycle.
- START (3 quarters): S0 SDA=1 SCL=1; S1 SDA=0 SCL=1; S2 SDA=0 SCL=0.
- BIT (4 quarters per bit, MSB first): Q0 SCL=0, SDA driven with the bit; Q1, Q2 SCL=1; Q3 SCL=0.
- Frame byte 0 is {slave_address, 1'b0}, followed by the data bytes.
- ACK (9th bit, same 4 quarters): SDA released; i2c_serial_data_input sampled on the Q1 tick.
  - 0 = ACK: load the next byte, or go to STOP after the last byte.
  - 1 = NACK: set ack_error, skip remaining bytes, go to STOP.
- STOP (3 quarters): P0 SDA=0 SCL=0; P1 SDA=0 SCL=1; P2 SDA=1 SCL=1.
- After the P2 tick: done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- Duration with no NACK: busy high for exactly CLK_DIV*(6+36*(N+1)) cycles, N = clamped byte_count.
- SDA changes only while SCL=0, except the START and STOP edges.
- Single FSM: IDLE, START, BIT, ACK, STOP, plus bit counter (0..7), byte counter (0..MAX_BYTES) and quarter counter (0..3).

Test Plan:
- CLK_DIV=4, addr=0x39, byte_count=2, data 0x41,0x10, slave always ACKs -> SDA bit stream 0x72,A,0x41,A,0x10,A between START/STOP; busy=456 cycles; done pulses once; ack_error=0.
- Same setup, slave NACKs the 2nd byte -> ack_error=1; the third byte is not sent; STOP follows the NACK; busy=CLK_DIV*(6+36*2)=312 cycles.
- byte_count=0, addr=0x39 -> one address byte plus ACK only; busy=168 cycles. byte_count=7 with MAX_BYTES=4 -> exactly 4 data bytes sent.
- Pulse start while busy; hold start high across done -> mid-transaction pulse ignored; the second transaction begins on the first IDLE cycle after done, and ack_error is cleared at accept.
- Assert reset in the middle of data byte 1 -> next cycle SCL=1, oe=0, busy=0, done=0; a subsequent start runs a full clean transaction.
- Protocol monitor over all tests -> no SDA transition while SCL=1 except START/STOP; the SCL high phase is always 2*CLK_DIV cycles.
